sram_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port 1024x32 SRAM macro (RM_IHPSG13_1P family) between `NUM_REQ` requesters inside `chip_core`.
- Each requester uses a valid/ready request channel and receives read data with a one-hot `rvalid`.
- A lock mechanism gives one requester bounded back-to-back ownership for bursts.
- The block drives the macro's functional port directly. BIST pins are tied off outside the block.

---
 rtl/sram_arbiter_if.sv | 38 +++
 rtl/sram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Request/response bundle between the requesters and sram_arbiter.
//   Modports:
//     master : requester side; drives the request channel and receives
//              req_ready plus the shared read response.
//     slave  : arbiter side.
//   Signals (requester i occupies bit i / slice i of each packed vector):
//     req_valid, req_ready, req_we, req_lock : NUM_REQ bits
//     req_addr  : NUM_REQ*ADDR_W
//     req_wdata : NUM_REQ*DATA_W
//     req_wmask : NUM_REQ*DATA_W, 1 = write the bit
//     rsp_rvalid: NUM_REQ, one-hot read-data valid
//     rsp_rdata : DATA_W, shared read data
interface sram_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*DATA_W-1:0] req_wmask;
  logic [NUM_REQ-1:0]        rsp_rvalid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_rvalid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_rvalid, rsp_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Round-robin arbiter sharing one single-port SRAM macro between NUM_REQ
//   requesters. A requester holding req_lock keeps the grant for up to
//   MAX_BURST back-to-back acceptances. The macro's functional port is
//   driven combinationally from the accepted request.
//   Ports:
//     clk, rst        : clock and synchronous active-high reset
//     bus (slave)     : request channel and one-hot read response
//     sram_men/wen/ren: macro enables
//     sram_addr       : macro word address
//     sram_din/sram_bm: macro write data and bit mask
//     sram_dout       : macro read data, valid one cycle after the access
//   Build option:
//     SRAM_ARB_OUTREG_EN : adds a register stage on rsp_rvalid/rsp_rdata,
//                          making read latency 2 cycles instead of 1.
module sram_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     bus,
  output logic              sram_men,
  output logic              sram_wen,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic [DATA_W-1:0] sram_bm,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [7:0]         burst_cnt, burst_cnt_n;
  logic [IDX_W-1:0]   win_idx, grant_idx;
  logic               win_found;
  logic               owner_take;
  logic               accept;
  logic               grant_we;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] rvalid_q;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && bus.req_valid[IDX_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  // Grant and next-state logic. Nothing is granted while rst is high.
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    owner_n     = owner;
    burst_cnt_n = burst_cnt;
    ready       = '0;
    grant_idx   = win_idx;
    owner_take  = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          grant_idx = win_idx;
          if (win_found) begin
            ready[win_idx] = 1'b1;
            rr_ptr_n       = next_idx(win_idx);
            // A single-transaction burst makes locking pointless.
            if (bus.req_lock[win_idx] && MAX_BURST > 1) begin
              state_n     = LOCKED;
              owner_n     = win_idx;
              burst_cnt_n = 8'd1;
            end
          end
        end
        LOCKED: begin
          grant_idx    = owner;
          owner_take   = bus.req_valid[owner];
          ready[owner] = owner_take;
          if (owner_take) burst_cnt_n = burst_cnt + 8'd1;
          // Lock drop still serves this edge's transaction; the burst
          // limit forces release on the acceptance that reaches it.
          if (!bus.req_lock[owner] ||
              (owner_take && burst_cnt_n == 8'(MAX_BURST))) begin
            state_n     = ARB;
            rr_ptr_n    = next_idx(owner);
            burst_cnt_n = '0;
          end
        end
        default: state_n = ARB;
      endcase
    end
  end

  assign accept        = |ready;
  assign bus.req_ready = ready;

  always_comb begin
    sram_men  = 1'b0;
    sram_wen  = 1'b0;
    sram_ren  = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    sram_bm   = '0;
    grant_we  = bus.req_we[grant_idx];
    if (accept) begin
      sram_men  = 1'b1;
      sram_wen  = grant_we;
      sram_ren  = !grant_we;
      sram_addr = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
      sram_din  = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
      sram_bm   = grant_we ? bus.req_wmask[grant_idx*DATA_W +: DATA_W] : '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      rvalid_q  <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      burst_cnt <= burst_cnt_n;
      rvalid_q  <= ready & ~bus.req_we;
    end
  end

`ifdef SRAM_ARB_OUTREG_EN
  logic [NUM_REQ-1:0] rvalid_q2;
  logic [DATA_W-1:0]  rdata_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q2 <= '0;
      rdata_q2  <= '0;
    end else begin
      rvalid_q2 <= rvalid_q;
      rdata_q2  <= sram_dout;
    end
  end

  assign bus.rsp_rvalid = rvalid_q2;
  assign bus.rsp_rdata  = rdata_q2;
`else
  assign bus.rsp_rvalid = rvalid_q;
  assign bus.rsp_rdata  = sram_dout;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter (NUM_REQ=3, MAX_BURST=4) with a
//   behavioural single-port SRAM model on the macro port.
//   Honours SRAM_ARB_OUTREG_EN for the expected read latency.
module tb_sram_arbiter;
  localparam int NUM_REQ   = 3;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
`ifdef SRAM_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic              sram_men, sram_wen, sram_ren;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din, sram_bm, sram_dout;
  logic [DATA_W-1:0] mem [1024];

  sram_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sram_men(sram_men), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_bm(sram_bm),
    .sram_dout(sram_dout)
  );

  // Single-port macro: bit-masked write, registered read.
  always @(posedge clk) begin
    if (sram_men) begin
      if (sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
      if (sram_ren) sram_dout <= mem[sram_addr];
    end
  end

  int errorCount = 0;
  int checkCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic valid, input logic we,
                               input logic lock, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata,
                               input logic [DATA_W-1:0] wmask);
    bus.req_valid[i] = valid;
    bus.req_we[i]    = we;
    bus.req_lock[i]  = lock;
    bus.req_addr[i*ADDR_W +: ADDR_W]  = addr;
    bus.req_wdata[i*DATA_W +: DATA_W] = wdata;
    bus.req_wmask[i*DATA_W +: DATA_W] = wmask;
  endtask

  task automatic clearAll();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lone write by requester i: checks grant and macro drive, then accepts.
  task automatic doWrite(input string tag, input int i, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] wmask);
    applyStimulus(i, 1'b1, 1'b1, 1'b0, addr, wdata, wmask);
    #1;
    checkOutput({tag, " ready"}, 32'(bus.req_ready), 32'(1) << i);
    checkOutput({tag, " wen"},   32'(sram_wen), 32'd1);
    checkOutput({tag, " bm"},    sram_bm, wmask);
    checkOutput({tag, " din"},   sram_din, wdata);
    tick();
    applyStimulus(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Lone read by requester i: checks grant, response after LAT cycles and
  // that the response is a single pulse.
  task automatic readCheck(input string tag, input int i, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] expData);
    applyStimulus(i, 1'b1, 1'b0, 1'b0, addr, '0, '0);
    #1;
    checkOutput({tag, " ready"}, 32'(bus.req_ready), 32'(1) << i);
    checkOutput({tag, " ren"},   32'(sram_ren), 32'd1);
    checkOutput({tag, " bm"},    sram_bm, 32'hFFFF_FFFF);
    checkOutput({tag, " addr"},  32'(sram_addr), 32'(addr));
    tick();
    applyStimulus(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int w = 0; w < LAT - 1; w++) tick();
    checkOutput({tag, " rvalid"}, 32'(bus.rsp_rvalid), 32'(1) << i);
    checkOutput({tag, " rdata"},  bus.rsp_rdata, expData);
    tick();
    checkOutput({tag, " rvalid pulse"}, 32'(bus.rsp_rvalid), 32'd0);
  endtask

  initial begin
    logic [2:0] lockSeq [6];
    lockSeq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    sram_dout = '0;
    rst = 1'b1;
    clearAll();
    tick();
    tick();

    // Reset: nothing granted or driven even with all requesters valid.
    for (int i = 0; i < NUM_REQ; i++)
      applyStimulus(i, 1'b1, 1'b0, 1'b0, ADDR_W'(10'h100 + i), '0, '0);
    #1;
    checkOutput("reset ready",  32'(bus.req_ready), 32'd0);
    checkOutput("reset men",    32'(sram_men), 32'd0);
    checkOutput("reset bm",     sram_bm, 32'd0);
    checkOutput("reset rvalid", 32'(bus.rsp_rvalid), 32'd0);

    // Round robin from reset: 0,1,2,0,1,2 with no gaps.
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput("rr ready", 32'(bus.req_ready), 32'(1) << (k % 3));
      checkOutput("rr addr",  32'(sram_addr), 32'h100 + 32'(k % 3));
      checkOutput("rr ren",   32'(sram_ren), 32'd1);
      tick();
    end
    clearAll();
    tick();
    tick();
    #1;
    checkOutput("idle men", 32'(sram_men), 32'd0);
    checkOutput("idle bm",  sram_bm, 32'd0);

    // Single read after write.
    doWrite("wr 005", 1, 10'h005, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    readCheck("rd 005", 1, 10'h005, 32'hDEAD_BEEF);

    // Bit mask.
    doWrite("bm full", 0, 10'h020, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    doWrite("bm half", 0, 10'h020, 32'h0000_0000, 32'h0000_FFFF);
    readCheck("bm rd", 0, 10'h020, 32'hFFFF_0000);

    // Move rr_ptr to 2 so requester 2 wins first, then lock bounding.
    readCheck("rr pos", 1, 10'h005, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 10'h040, '0, '0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 10'h041, '0, '0);
    applyStimulus(2, 1'b1, 1'b0, 1'b1, 10'h042, '0, '0);
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput("lock bound ready", 32'(bus.req_ready), 32'(lockSeq[k]));
      tick();
    end
    clearAll();
    tick();

    // Early unlock: requester 0 locks, drops lock on its 2nd accept.
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 10'h050, '0, '0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 10'h051, '0, '0);
    #1;
    checkOutput("unlock grant1", 32'(bus.req_ready), 32'd1);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 10'h050, '0, '0);
    #1;
    checkOutput("unlock grant2", 32'(bus.req_ready), 32'd1);
    tick();
    #1;
    checkOutput("unlock next", 32'(bus.req_ready), 32'd2);
    tick();
    clearAll();
    tick();

    // Reset on the cycle after a read accept.
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 10'h005, '0, '0);
    #1;
    checkOutput("rstmid ready", 32'(bus.req_ready), 32'd2);
    tick();
    clearAll();
    rst = 1'b1;
    tick();
    checkOutput("rstmid rvalid a", 32'(bus.rsp_rvalid), 32'd0);
    for (int i = 0; i < NUM_REQ; i++)
      applyStimulus(i, 1'b1, 1'b0, 1'b0, ADDR_W'(10'h060 + i), '0, '0);
    #1;
    checkOutput("rstmid ready held", 32'(bus.req_ready), 32'd0);
    checkOutput("rstmid men held",   32'(sram_men), 32'd0);
    tick();
    checkOutput("rstmid rvalid b", 32'(bus.rsp_rvalid), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rstmid next grant", 32'(bus.req_ready), 32'd1);
    tick();
    clearAll();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
